// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM encoding, stall masks and bus constants for pipe_ctrl
package pipe_pkg;
  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic Stop = 1'b1;
  localparam logic NoStop = 1'b0;
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_e;
  // stall_o bit order: 0=pc 1=if 2=id 3=ex 4=mem 5=wb
  localparam logic [5:0] STALL_NONE = {6{NoStop}};
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
endpackage

// File: rtl/stall_wdog.sv
// stall_wdog: saturating 16-bit stall counter with sticky timeout flag
// Ports: clk_i, n_rst_i (async active-low), en_i (count this cycle, else clear),
//        timeout_o (sticky once the count reaches LIMIT, cleared only by reset)
module stall_wdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic n_rst_i,
  input  logic en_i,
  output logic timeout_o
);
  logic [15:0] cnt_q, cnt_d;
  logic to_q, to_d;
  always_comb begin
    cnt_d = !en_i ? 16'd0 : (&cnt_q) ? cnt_q : cnt_q + 16'd1;
    to_d  = to_q | (32'(cnt_d) >= LIMIT);
  end
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cnt_q <= 16'd0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
  assign timeout_o = to_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/debug-halt controller
// Ports: clk_i, n_rst_i (async active-low); stallreq_{if,id,ex,mem}_i stage stall
//        requests; trap_i/trap_pc_i accepted trap and handler PC; halt_req_i (level),
//        resume_i (pulse) debug control; stall_o[5:0] pc..wb stalls; flush_o/new_pc_o
//        redirect; halted_o; stall_timeout_o sticky watchdog flag.
// Optional: define PIPE_CTRL_WDOG_EN to build the stall watchdog (else tied 0).
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              stallreq_if_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              stallreq_mem_i,
  input  logic              trap_i,
  input  logic [RegBus-1:0] trap_pc_i,
  input  logic              halt_req_i,
  input  logic              resume_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [RegBus-1:0] new_pc_o,
  output logic              halted_o,
  output logic              stall_timeout_o
);
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [5:0] req_mask;
  logic any_req, active, trap_take;
  if (WDOG_LIMIT < 2 || WDOG_LIMIT > 65535) begin : g_bad_limit
    $error("pipe_ctrl: WDOG_LIMIT out of range 2..65535");
  end
  assign req_mask  = stallreq_mem_i ? STALL_MEM : stallreq_ex_i ? STALL_EX :
                     stallreq_id_i ? STALL_ID : stallreq_if_i ? STALL_IF : STALL_NONE;
  assign any_req   = stallreq_if_i | stallreq_id_i | stallreq_ex_i | stallreq_mem_i;
  assign active    = (state_q == RUN) || (state_q == DRAIN);
  // outputs are gated by n_rst_i so they read idle for the whole reset assertion
  assign trap_take = n_rst_i && active && trap_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (trap_i) state_d = FLUSH;
        else if (halt_req_i) begin
          state_d = DRAIN;
          cnt_d   = 2'd0;
        end
      end
      FLUSH: state_d = RUN;
      DRAIN: begin
        if (trap_i) state_d = FLUSH;
        else if (!halt_req_i) state_d = RUN;
        else if (!any_req) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = HALTED;
        end
      end
      HALTED: if (resume_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign stall_o  = (!n_rst_i || trap_take) ? STALL_NONE :
                    (state_q == RUN)    ? req_mask :
                    (state_q == DRAIN)  ? (req_mask | STALL_IF) :
                    (state_q == HALTED) ? {6{Stop}} : STALL_NONE;
  assign flush_o  = trap_take;
  assign new_pc_o = trap_take ? trap_pc_i : ZeroWord;
  assign halted_o = n_rst_i && (state_q == HALTED);
`ifdef PIPE_CTRL_WDOG_EN
  stall_wdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
    .clk_i     (clk_i),
    .n_rst_i   (n_rst_i),
    .en_i      (active && any_req && !trap_take),
    .timeout_o (stall_timeout_o)
  );
`else
  assign stall_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_pipe_ctrl;
  typedef struct packed {
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic        hl;
    logic        to;
  } exp_t;
`ifdef PIPE_CTRL_WDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic s_if = 1'b0, s_id = 1'b0, s_ex = 1'b0, s_mem = 1'b0;
  logic trap = 1'b0, halt = 1'b0, res = 1'b0;
  logic [31:0] tpc = '0;
  logic [5:0] stall;
  logic flush, halted, tout;
  logic [31:0] npc;
  exp_t eq[$];
  string nq[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pipe_ctrl #(.WDOG_LIMIT(8)) dut (
    .clk_i(clk), .n_rst_i(n_rst),
    .stallreq_if_i(s_if), .stallreq_id_i(s_id), .stallreq_ex_i(s_ex), .stallreq_mem_i(s_mem),
    .trap_i(trap), .trap_pc_i(tpc), .halt_req_i(halt), .resume_i(res),
    .stall_o(stall), .flush_o(flush), .new_pc_o(npc), .halted_o(halted),
    .stall_timeout_o(tout)
  );
  // req = {mem, ex, id, if}
  task automatic drv(input string nm, input logic rst, input logic [3:0] req, input logic tr,
                     input logic [31:0] pc_in, input logic hr, input logic rs,
                     input logic [5:0] st, input logic fl, input logic [31:0] pc,
                     input logic hl, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    n_rst = rst;
    {s_mem, s_ex, s_id, s_if} = req;
    trap = tr;
    tpc = pc_in;
    halt = hr;
    res = rs;
    e = '{st: st, fl: fl, pc: pc, hl: hl, to: to & WD};
    eq.push_back(e);
    nq.push_back(nm);
  endtask
  always @(negedge clk) begin
    if (eq.size() > 0) begin
      exp_t e;
      string n;
      e = eq.pop_front();
      n = nq.pop_front();
      checks++;
      if ({stall, flush, npc, halted, tout} !== e) begin
        errors++;
        $display("FAIL %s: got stall=%b flush=%b pc=%h halted=%b to=%b exp stall=%b flush=%b pc=%h halted=%b to=%b",
                 n, stall, flush, npc, halted, tout, e.st, e.fl, e.pc, e.hl, e.to);
      end
    end
  end
  initial begin
    //   name           rst req     trap pc            hlt res  stall      fl pc            hl to
    drv("reset",        0, 4'b1000, 1, 32'h80000100, 1, 0, 6'b000000, 0, 32'h0,        0, 0);
    drv("idle",         1, 4'b0000, 0, 32'h0,        0, 0, 6'b000000, 0, 32'h0,        0, 0);
    drv("req_if",       1, 4'b0001, 0, 32'h0,        0, 0, 6'b000011, 0, 32'h0,        0, 0);
    drv("req_id",       1, 4'b0010, 0, 32'h0,        0, 0, 6'b000111, 0, 32'h0,        0, 0);
    drv("req_ex_mem",   1, 4'b1100, 0, 32'h0,        0, 0, 6'b011111, 0, 32'h0,        0, 0);
    drv("release",      1, 4'b0000, 0, 32'h0,        0, 0, 6'b000000, 0, 32'h0,        0, 0);
    drv("req_ex",       1, 4'b0100, 0, 32'h0,        0, 0, 6'b001111, 0, 32'h0,        0, 0);
    drv("trap",         1, 4'b1000, 1, 32'h80000100, 0, 0, 6'b000000, 1, 32'h80000100, 0, 0);
    drv("flush_hold",   1, 4'b1000, 1, 32'h80000100, 0, 0, 6'b000000, 0, 32'h0,        0, 0);
    drv("post_flush",   1, 4'b0000, 0, 32'h0,        0, 0, 6'b000000, 0, 32'h0,        0, 0);
    drv("halt_req",     1, 4'b0000, 0, 32'h0,        1, 0, 6'b000000, 0, 32'h0,        0, 0);
    for (int i = 0; i < 3; i++)
      drv("drain_mem",  1, 4'b1000, 0, 32'h0,        1, 0, 6'b011111, 0, 32'h0,        0, 0);
    for (int i = 0; i < 4; i++)
      drv("drain_cnt",  1, 4'b0000, 0, 32'h0,        1, 0, 6'b000011, 0, 32'h0,        0, 0);
    drv("halted",       1, 4'b1000, 1, 32'h12345678, 1, 0, 6'b111111, 0, 32'h0,        1, 0);
    drv("resume",       1, 4'b0000, 0, 32'h0,        0, 1, 6'b111111, 0, 32'h0,        1, 0);
    drv("run_again",    1, 4'b0000, 0, 32'h0,        0, 0, 6'b000000, 0, 32'h0,        0, 0);
    drv("halt2",        1, 4'b0000, 0, 32'h0,        1, 0, 6'b000000, 0, 32'h0,        0, 0);
    drv("drain2",       1, 4'b0000, 0, 32'h0,        1, 0, 6'b000011, 0, 32'h0,        0, 0);
    drv("drain_trap",   1, 4'b0000, 1, 32'h00001234, 1, 0, 6'b000000, 1, 32'h00001234, 0, 0);
    drv("flush2",       1, 4'b0000, 0, 32'h0,        1, 0, 6'b000000, 0, 32'h0,        0, 0);
    drv("run_halt",     1, 4'b0001, 0, 32'h0,        1, 0, 6'b000011, 0, 32'h0,        0, 0);
    drv("drain3",       1, 4'b0001, 0, 32'h0,        1, 0, 6'b000011, 0, 32'h0,        0, 0);
    drv("drain_abort",  1, 4'b0010, 0, 32'h0,        0, 0, 6'b000111, 0, 32'h0,        0, 0);
    drv("run_idle",     1, 4'b0000, 0, 32'h0,        0, 0, 6'b000000, 0, 32'h0,        0, 0);
    for (int i = 0; i < 8; i++)
      drv("wdog_cnt",   1, 4'b0010, 0, 32'h0,        0, 0, 6'b000111, 0, 32'h0,        0, 0);
    drv("wdog_set",     1, 4'b0000, 0, 32'h0,        0, 0, 6'b000000, 0, 32'h0,        0, 1);
    drv("wdog_sticky",  1, 4'b0000, 0, 32'h0,        0, 0, 6'b000000, 0, 32'h0,        0, 1);
    drv("halt3",        1, 4'b0000, 0, 32'h0,        1, 0, 6'b000000, 0, 32'h0,        0, 1);
    for (int i = 0; i < 4; i++)
      drv("drain4",     1, 4'b0000, 0, 32'h0,        1, 0, 6'b000011, 0, 32'h0,        0, 1);
    drv("halted2",      1, 4'b0000, 0, 32'h0,        1, 0, 6'b111111, 0, 32'h0,        1, 1);
    drv("rst_halted",   0, 4'b0000, 0, 32'h0,        0, 0, 6'b000000, 0, 32'h0,        0, 0);
    drv("after_rst",    1, 4'b0000, 0, 32'h0,        0, 0, 6'b000000, 0, 32'h0,        0, 0);
    drv("after_rst_id", 1, 4'b0010, 0, 32'h0,        0, 0, 6'b000111, 0, 32'h0,        0, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending exp 0", eq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
